// File: rtl/ram_access_arbiter_pkg.sv
// Shared definitions for the program/data RAM access arbiter: FSM states,
// requester port indices and default RAM geometry.
package ram_access_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RWAIT  = 2'd2
  } state_e;

  // One-hot per-port strobe for a given port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_rr_arbiter2.sv
// Two-port winner select: a lone requester always wins; on contention the
// loader wins while the CPU is halted, otherwise the port not granted last wins.
module ram_access_arbiter_rr_arbiter2
  import ram_access_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       cpu_halt,
  output logic       valid_c,
  output logic       winner_c
);

  always_comb begin
    valid_c  = |req;
    winner_c = PORT_CPU;
    case (req)
      2'b01:   winner_c = PORT_CPU;
      2'b10:   winner_c = PORT_LDR;
      2'b11:   winner_c = cpu_halt ? PORT_LDR
                                   : ((last_grant == PORT_CPU) ? PORT_LDR : PORT_CPU);
      default: winner_c = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Serialises single-beat CPU/loader accesses onto the shared RAM, driving its
// address/enable pins and returning read data with a one-cycle valid strobe.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_halt,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              owner,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ce_n,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = 2;

  state_e            state, state_nx;
  logic              last_grant, last_grant_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              win_valid, win;

  logic [1:0]        gnt_nx, rvalid_nx;
  logic [DATA_W-1:0] rdata_nx, ram_wdata_nx;
  logic [ADDR_W-1:0] ram_addr_nx;
  logic              busy_nx, owner_nx, ram_ce_n_nx, ram_we_nx;

  ram_access_arbiter_rr_arbiter2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .cpu_halt   (cpu_halt),
    .valid_c    (win_valid),
    .winner_c   (win)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    cnt_nx        = cnt;
    gnt_nx        = 2'b00;
    rvalid_nx     = 2'b00;
    rdata_nx      = rdata;
    owner_nx      = owner;
    ram_addr_nx   = ram_addr;
    ram_wdata_nx  = ram_wdata;
    ram_ce_n_nx   = 1'b1;
    ram_we_nx     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          owner_nx      = win;
          last_grant_nx = win;
          ram_addr_nx   = win ? addr1 : addr0;
          ram_wdata_nx  = win ? wdata1 : wdata0;
          ram_we_nx     = we[win];
          ram_ce_n_nx   = 1'b0;
          gnt_nx        = port_onehot(win);
          state_nx      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (ram_we) begin
          state_nx = ST_IDLE;
        end else begin
          ram_ce_n_nx = 1'b0;
          cnt_nx      = CNT_W'(READ_LAT - 1);
          state_nx    = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (cnt == '0) begin
          rdata_nx  = ram_rdata;
          rvalid_nx = port_onehot(owner);
          state_nx  = ST_IDLE;
        end else begin
          ram_ce_n_nx = 1'b0;
          cnt_nx      = cnt - CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= PORT_LDR;
      cnt        <= '0;
      gnt        <= 2'b00;
      rvalid     <= 2'b00;
      rdata      <= '0;
      busy       <= 1'b0;
      owner      <= PORT_CPU;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_ce_n   <= 1'b1;
      ram_we     <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      cnt        <= cnt_nx;
      gnt        <= gnt_nx;
      rvalid     <= rvalid_nx;
      rdata      <= rdata_nx;
      busy       <= busy_nx;
      owner      <= owner_nx;
      ram_addr   <= ram_addr_nx;
      ram_wdata  <= ram_wdata_nx;
      ram_ce_n   <= ram_ce_n_nx;
      ram_we     <= ram_we_nx;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: two instances (read latency 1 and 3), each with
// its own RAM model, checked against a transaction-level reference.
module tb_ram_access_arbiter;
  import ram_access_arbiter_pkg::*;

  logic       clk;
  logic       rst_n    [2];
  logic       cpu_halt [2];
  logic [1:0] req      [2];
  logic [1:0] we       [2];
  logic [3:0] addr0    [2];
  logic [3:0] addr1    [2];
  logic [7:0] wdata0   [2];
  logic [7:0] wdata1   [2];
  logic [1:0] gnt      [2];
  logic [1:0] rvalid   [2];
  logic [7:0] rdata    [2];
  logic       busy     [2];
  logic       owner    [2];
  logic [3:0] ram_addr [2];
  logic [7:0] ram_wdata[2];
  logic       ram_ce_n [2];
  logic       ram_we   [2];
  logic [7:0] ram_rdata[2];

  logic [7:0] ram_mem [2][16];
  logic [7:0] pipe    [2][3];
  logic       pl_en;
  int         pl_k;
  logic [3:0] pl_a;
  logic [7:0] pl_d;

  logic       ref_last [2];
  logic [7:0] ref_mem  [2][16];

  int checks = 0;
  int errors = 0;
  int cur_k  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    ram_access_arbiter #(.ADDR_W(4), .DATA_W(8), .READ_LAT(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .cpu_halt  (cpu_halt[g]),
      .req       (req[g]),
      .we        (we[g]),
      .addr0     (addr0[g]),
      .addr1     (addr1[g]),
      .wdata0    (wdata0[g]),
      .wdata1    (wdata1[g]),
      .gnt       (gnt[g]),
      .rvalid    (rvalid[g]),
      .rdata     (rdata[g]),
      .busy      (busy[g]),
      .owner     (owner[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_ce_n  (ram_ce_n[g]),
      .ram_we    (ram_we[g]),
      .ram_rdata (ram_rdata[g])
    );
    assign ram_rdata[g] = pipe[g][LAT-1];
  end

  // RAM macro model: write on ce_n low + we, read data appears LAT cycles after ce_n low.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pl_en && pl_k == k) ram_mem[k][pl_a] <= pl_d;
      else if (!ram_ce_n[k] && ram_we[k]) ram_mem[k][ram_addr[k]] <= ram_wdata[k];
      pipe[k][0] <= (!ram_ce_n[k] && !ram_we[k]) ? ram_mem[k][ram_addr[k]] : 8'hxx;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic pick(input logic [1:0] r, input logic halt, input logic last);
    if (r == 2'b11) return halt ? 1'b1 : (last == 1'b0);
    return r[1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
    end
  endtask

  task automatic preload(input int k, input logic [3:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_k = k; pl_a = a; pl_d = d;
    ref_mem[k][a] = d;
    tick();
    pl_en = 1'b0;
  endtask

  // One complete transaction from an idle arbiter, checked cycle by cycle.
  task automatic txn(input int k, input logic [1:0] r, input logic [1:0] w,
                     input logic [3:0] a0, input logic [3:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1, input logic halt);
    logic       win;
    logic [3:0] a;
    logic [7:0] d;
    logic [1:0] oh;
    cur_k = k;
    req[k] = r; we[k] = w; addr0[k] = a0; addr1[k] = a1;
    wdata0[k] = d0; wdata1[k] = d1; cpu_halt[k] = halt;
    tick();
    if (r == 2'b00) begin
      check("idle_gnt", 32'(gnt[k]), 32'h0);
      check("idle_busy", 32'(busy[k]), 32'h0);
      return;
    end
    win = pick(r, halt, ref_last[k]);
    ref_last[k] = win;
    a  = win ? a1 : a0;
    d  = win ? d1 : d0;
    oh = win ? 2'b10 : 2'b01;
    req[k] = 2'b00;
    check("gnt", 32'(gnt[k]), 32'(oh));
    check("acc_ce_n", 32'(ram_ce_n[k]), 32'h0);
    check("acc_addr", 32'(ram_addr[k]), 32'(a));
    check("acc_we", 32'(ram_we[k]), 32'(w[win]));
    check("owner", 32'(owner[k]), 32'(win));
    check("acc_busy", 32'(busy[k]), 32'h1);
    if (w[win]) begin
      check("acc_wdata", 32'(ram_wdata[k]), 32'(d));
      ref_mem[k][a] = d;
      tick();
      check("wr_done_busy", 32'(busy[k]), 32'h0);
      check("wr_done_ce_n", 32'(ram_ce_n[k]), 32'h1);
      check("wr_done_gnt", 32'(gnt[k]), 32'h0);
    end else begin
      for (int i = 0; i < lat_of(k); i++) begin
        tick();
        check("rwait_rvalid", 32'(rvalid[k]), 32'h0);
        check("rwait_ce_n", 32'(ram_ce_n[k]), 32'h0);
        check("rwait_we", 32'(ram_we[k]), 32'h0);
      end
      tick();
      check("rvalid", 32'(rvalid[k]), 32'(oh));
      check("rdata", 32'(rdata[k]), 32'(ref_mem[k][a]));
      check("rd_done_busy", 32'(busy[k]), 32'h0);
      check("rd_done_ce_n", 32'(ram_ce_n[k]), 32'h1);
    end
  endtask

  // Both ports hold write requests continuously; grants every other cycle.
  task automatic contend(input int k, input logic halt);
    logic win;
    cur_k = k;
    req[k] = 2'b11; we[k] = 2'b11; cpu_halt[k] = halt;
    addr0[k] = 4'h1; addr1[k] = 4'h2; wdata0[k] = 8'h11; wdata1[k] = 8'h22;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        win = pick(2'b11, halt, ref_last[k]);
        ref_last[k] = win;
        ref_mem[k][win ? 4'h2 : 4'h1] = win ? 8'h22 : 8'h11;
        check(halt ? "halt_gnt" : "rr_gnt", 32'(gnt[k]), win ? 32'h2 : 32'h1);
      end else begin
        check("contend_gap", 32'(gnt[k]), 32'h0);
      end
      if (i == 6) req[k] = 2'b00;
    end
    tick();
    check("contend_end", 32'(gnt[k]), 32'h0);
  endtask

  initial begin
    pl_en = 1'b0; pl_k = 0; pl_a = '0; pl_d = '0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; cpu_halt[k] = 1'b0; req[k] = '0; we[k] = '0;
      addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) preload(k, 4'(a), 8'($urandom));
      preload(k, 4'h3, 8'hA5);
    end

    for (int k = 0; k < 2; k++) begin
      cur_k = k;
      check("rst_gnt", 32'(gnt[k]), 32'h0);
      check("rst_rvalid", 32'(rvalid[k]), 32'h0);
      check("rst_rdata", 32'(rdata[k]), 32'h0);
      check("rst_busy", 32'(busy[k]), 32'h0);
      check("rst_owner", 32'(owner[k]), 32'h0);
      check("rst_addr", 32'(ram_addr[k]), 32'h0);
      check("rst_wdata", 32'(ram_wdata[k]), 32'h0);
      check("rst_ce_n", 32'(ram_ce_n[k]), 32'h1);
      check("rst_we", 32'(ram_we[k]), 32'h0);
      rst_n[k] = 1'b1;
      ref_last[k] = 1'b1;
    end
    tick();

    // Directed: CPU read of the preloaded word, then a loader write.
    for (int k = 0; k < 2; k++) begin
      txn(k, 2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00, 1'b0);
      check("read_a5", 32'(rdata[k]), 32'hA5);
      txn(k, 2'b10, 2'b10, 4'h0, 4'hF, 8'h00, 8'h3C, 1'b0);
      check("mem_f", 32'(ram_mem[k][15]), 32'h3C);
    end

    contend(0, 1'b0);
    contend(0, 1'b1);
    txn(0, 2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 1'b0);
    check("unhalt_cpu", 32'(owner[0]), 32'(PORT_CPU));

    // Loader write in flight; a one-cycle CPU request during ACCESS is dropped.
    cur_k = 0;
    req[0] = 2'b10; we[0] = 2'b10; addr1[0] = 4'h9; wdata1[0] = 8'h77; cpu_halt[0] = 1'b0;
    tick();
    check("wd_ldr_gnt", 32'(gnt[0]), 32'h2);
    ref_last[0] = 1'b1;
    ref_mem[0][9] = 8'h77;
    req[0] = 2'b01; we[0] = 2'b00; addr0[0] = 4'h4;
    tick();
    check("wd_busy", 32'(busy[0]), 32'h0);
    req[0] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wd_no_gnt", 32'(gnt[0]), 32'h0);
    end

    // Randomized traffic against the reference.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 60; n++) begin
        txn(k, 2'($urandom_range(0, 3)), 2'($urandom), 4'($urandom), 4'($urandom),
            8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
      end
    end

    // Reset during RWAIT of a latency-3 read.
    cur_k = 1;
    req[1] = 2'b01; we[1] = 2'b00; addr0[1] = 4'h3; cpu_halt[1] = 1'b0;
    tick();
    check("mr_gnt", 32'(gnt[1]), 32'h1);
    req[1] = 2'b00;
    tick();
    rst_n[1] = 1'b0;
    tick();
    check("mr_busy", 32'(busy[1]), 32'h0);
    check("mr_ce_n", 32'(ram_ce_n[1]), 32'h1);
    check("mr_rdata", 32'(rdata[1]), 32'h0);
    rst_n[1] = 1'b1;
    ref_last[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("mr_no_rvalid", 32'(rvalid[1]), 32'h0);
      tick();
    end
    txn(1, 2'b11, 2'b00, 4'h3, 4'hF, 8'h00, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
